// File: rtl/sequential_cla_subtractor_if.sv
// Operand/result handshake bundle for the sequential CLA subtractor.
// The master side supplies operands and consumes the result; the slave side is the subtractor.
interface sequential_cla_subtractor_if #(
    parameter int WIDTH = 64
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_min;
    logic [WIDTH-1:0] i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH:0]   o_result;

    modport master (
        output i_valid, i_min, i_sub, i_ready,
        input  o_ready, o_valid, o_result
    );

    modport slave (
        input  i_valid, i_min, i_sub, i_ready,
        output o_ready, o_valid, o_result
    );
endinterface

// File: rtl/sequential_cla_subtractor.sv
// Multi-cycle unsigned subtractor: i_min - i_sub computed as i_min + ~i_sub + 1,
// one SLICE-bit carry-lookahead slice per cycle with the inter-slice carry registered.
// o_result = {borrow, diff}, borrow set when i_min < i_sub.
module sequential_cla_subtractor #(
    parameter int WIDTH = 64,
    parameter int SLICE = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    sequential_cla_subtractor_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
        $error("sequential_cla_subtractor: WIDTH must be a multiple of SLICE");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   result_q;

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] sum_slice;
    logic             slice_cout;
    logic             accept;
    logic             last_slice;

    assign accept     = bus.i_valid && (state_q == IDLE);
    assign last_slice = (cnt_q == CNT_W'(NSLICE - 1));

    // Select the operand slice addressed by the slice counter.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int unsigned s = 0; s < NSLICE; s++) begin
            if (cnt_q == CNT_W'(s)) begin
                a_slice = a_q[s*SLICE +: SLICE];
                b_slice = b_q[s*SLICE +: SLICE];
            end
        end
    end

    // Slice adder: generate/propagate carry recurrence seeded by the registered carry.
    always_comb begin
        logic c;
        c         = carry_q;
        sum_slice = '0;
        for (int unsigned k = 0; k < SLICE; k++) begin
            sum_slice[k] = a_slice[k] ^ b_slice[k] ^ c;
            c            = (a_slice[k] & b_slice[k]) | ((a_slice[k] | b_slice[k]) & c);
        end
        slice_cout = c;
    end

    // Control FSM and datapath registers; the counter holds at the last slice rather than wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= bus.i_min;
                        b_q     <= ~bus.i_sub;
                        carry_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    for (int unsigned s = 0; s < NSLICE; s++) begin
                        if (cnt_q == CNT_W'(s)) begin
                            result_q[s*SLICE +: SLICE] <= sum_slice;
                        end
                    end
                    carry_q <= slice_cout;
                    if (last_slice) begin
                        result_q[WIDTH] <= ~slice_cout;
                        state_q         <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready  = (state_q == IDLE) && i_rst_n;
    assign bus.o_valid  = (state_q == DONE);
    assign bus.o_result = result_q;
endmodule

// File: tb/tb_sequential_cla_subtractor.sv
// Self-checking bench for sequential_cla_subtractor: directed cases on a SLICE=16 build,
// then randomized operations on SLICE=16, 8 and 64 builds against a plain-arithmetic model.
module tb_sequential_cla_subtractor;
    localparam int WIDTH = 64;
    localparam int NSL16 = 4;

    logic clk = 1'b0;
    logic rst_n;
    bit   go_alt = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sequential_cla_subtractor_if #(.WIDTH(WIDTH)) bus ();

    sequential_cla_subtractor #(.WIDTH(WIDTH), .SLICE(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic check_val(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: zero-extended unsigned difference; bit WIDTH is the borrow.
    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    function automatic logic [WIDTH-1:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n = 0;
        while (bus.o_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check_val("send_ready_timeout", 65'(bus.o_ready), 65'(1));
        bus.i_valid = 1'b1;
        bus.i_min   = a;
        bus.i_sub   = b;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.o_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (bus.o_valid !== 1'b1) check_val("done_timeout", 65'(bus.o_valid), 65'(1));
    endtask

    task automatic take();
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold,
                          input string tag, output logic [WIDTH:0] res);
        int lat;
        send(a, b);
        wait_done(lat);
        check_val({tag, "_lat"}, 65'(lat), 65'(NSL16));
        res = bus.o_result;
        check_val({tag, "_res"}, res, ref_sub(a, b));
        for (int i = 0; i < hold; i++) begin
            bus.i_valid = 1'($urandom_range(0, 1));
            bus.i_min   = rand64();
            bus.i_sub   = rand64();
            @(negedge clk);
            check_val({tag, "_hold_valid"}, 65'(bus.o_valid), 65'(1));
            check_val({tag, "_hold_res"}, bus.o_result, res);
            check_val({tag, "_hold_ready"}, 65'(bus.o_ready), 65'(0));
        end
        bus.i_valid = 1'b0;
        take();
        check_val({tag, "_clr_valid"}, 65'(bus.o_valid), 65'(0));
        check_val({tag, "_clr_ready"}, 65'(bus.o_ready), 65'(1));
    endtask

    initial begin
        logic [WIDTH:0]   res;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               lat;
        int               n;

        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_min   = '0;
        bus.i_sub   = '0;
        rst_n       = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check_val("rst_ready", 65'(bus.o_ready), 65'(0));
        check_val("rst_valid", 65'(bus.o_valid), 65'(0));
        check_val("rst_result", bus.o_result, 65'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_val("rst_rel_ready", 65'(bus.o_ready), 65'(1));
        @(negedge clk);

        run_op(64'h10, 64'h3, 0, "t1", res);
        check_val("t1_const", res, {1'b0, 64'hD});
        run_op(64'h0, 64'h1, 0, "t2", res);
        check_val("t2_const", res, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        run_op(64'h0001_0000_0000_0000, 64'h1, 0, "t3", res);
        check_val("t3_const", res, {1'b0, 64'h0000_FFFF_FFFF_FFFF});
        run_op(64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 6, "t4", res);
        check_val("t4_const", res, 65'(0));

        // Operand/ready activity while calculating must not disturb the accepted operation.
        a = 64'h1234_5678_9ABC_DEF0;
        b = 64'h0FED_CBA9_8765_4321;
        send(a, b);
        for (int i = 0; i < 3; i++) begin
            check_val("t5_ready_calc", 65'(bus.o_ready), 65'(0));
            bus.i_valid = ~bus.i_valid;
            bus.i_min   = rand64();
            bus.i_sub   = rand64();
            bus.i_ready = 1'b1;
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        wait_done(lat);
        check_val("t5_lat", 65'(lat), 65'(1));
        check_val("t5_res", bus.o_result, ref_sub(a, b));
        take();

        // Reset during the second calculation cycle.
        send(64'h0000_0000_0000_00FF, 64'h1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("t6_calc_rst_valid", 65'(bus.o_valid), 65'(0));
        check_val("t6_calc_rst_result", bus.o_result, 65'(0));
        check_val("t6_calc_rst_ready", 65'(bus.o_ready), 65'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_val("t6_rel_ready", 65'(bus.o_ready), 65'(1));
        @(negedge clk);
        run_op(64'hFFFF_0000_1111_2222, 64'h3333_4444_5555_6666, 0, "t6_after", res);

        // Reset while a result is being presented.
        send(64'h5, 64'h9);
        wait_done(lat);
        #1 rst_n = 1'b0;
        #1;
        check_val("t6_done_rst_valid", 65'(bus.o_valid), 65'(0));
        check_val("t6_done_rst_result", bus.o_result, 65'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        go_alt = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = rand64();
            case ($urandom_range(0, 4))
                0: b = rand64();
                1: b = a;
                2: begin a = '0; b = rand64(); end
                3: b = '1;
                default: b = a + 64'($urandom_range(0, 3)) - 64'd1;
            endcase
            run_op(a, b, $urandom_range(0, 3), $sformatf("rnd16_%0d", i), res);
        end

        n = 0;
        while (!(alt[0].done_f && alt[1].done_f) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n == 5000) check_val("alt_timeout", 65'(alt[0].done_f && alt[1].done_f), 65'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    for (genvar g = 0; g < 2; g++) begin : alt
        localparam int SL = (g == 0) ? 8 : 64;
        localparam int NS = WIDTH / SL;

        bit done_f = 1'b0;

        sequential_cla_subtractor_if #(.WIDTH(WIDTH)) abus ();

        sequential_cla_subtractor #(.WIDTH(WIDTH), .SLICE(SL)) adut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (abus)
        );

        initial begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            int               n;

            abus.i_valid = 1'b0;
            abus.i_ready = 1'b0;
            abus.i_min   = '0;
            abus.i_sub   = '0;
            wait (go_alt);
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                a = rand64();
                b = (i % 5 == 0) ? a : rand64();
                if (i % 7 == 3) b = a + 64'd1;
                n = 0;
                while (abus.o_ready !== 1'b1 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                if (n == 20) check_val($sformatf("alt%0d_ready_timeout", SL), 65'(abus.o_ready), 65'(1));
                abus.i_valid = 1'b1;
                abus.i_min   = a;
                abus.i_sub   = b;
                @(negedge clk);
                abus.i_valid = 1'b0;
                n = 0;
                while (abus.o_valid !== 1'b1 && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check_val($sformatf("alt%0d_lat", SL), 65'(n), 65'(NS));
                check_val($sformatf("alt%0d_res_%0d", SL, i), abus.o_result, ref_sub(a, b));
                abus.i_ready = 1'b1;
                @(negedge clk);
                abus.i_ready = 1'b0;
                check_val($sformatf("alt%0d_clr_valid", SL), 65'(abus.o_valid), 65'(0));
            end
            done_f = 1'b1;
        end
    end
endmodule
